hamming74_scrubber: RTL and testbench

Memory scrubber that owns the SECDED (8,4) codec for a small codeword RAM. On request it walks every address, reads the stored 8-bit Hamming(7,4)+overall-parity codeword, classifies it, writes corrected words back, and reports per-pass error statistics. It sits between the system control logic (start/done) and a single-port synchronous RAM, and shares no port with other requesters during a pass.

---
 rtl/hamming74_pkg.sv | 62 ++++++
 rtl/hamming74_secded_dec.sv | 41 ++++
 rtl/hamming74_scrubber.sv | 163 ++++++++++++++++
 tb/tb_hamming74_scrubber.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming74_pkg.sv
// ---------------------------------------------------------------------------
// hamming74_pkg
// Shared definitions for the SECDED (8,4) scrubber:
//   - state_e      : scrubber FSM states
//   - err_class_e  : decoder classification of one codeword
//   - POS_*        : bit positions of parity/data bits inside a codeword
//   - encode()     : 4-bit data -> 8-bit codeword
//   - syndrome()   : 8-bit codeword -> 3-bit Hamming syndrome {s4,s2,s1}
// ---------------------------------------------------------------------------
package hamming74_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CHK  = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_CLEAN  = 2'd0,
        ERR_SINGLE = 2'd1,
        ERR_PARITY = 2'd2,
        ERR_DOUBLE = 2'd3
    } err_class_e;

    localparam int unsigned POS_P1 = 0;
    localparam int unsigned POS_P2 = 1;
    localparam int unsigned POS_D0 = 2;
    localparam int unsigned POS_P4 = 3;
    localparam int unsigned POS_D1 = 4;
    localparam int unsigned POS_D2 = 5;
    localparam int unsigned POS_D3 = 6;
    localparam int unsigned POS_P0 = 7;

    function automatic logic [7:0] encode(input logic [3:0] d);
        logic [7:0] cw;
        cw         = '0;
        cw[POS_D0] = d[0];
        cw[POS_D1] = d[1];
        cw[POS_D2] = d[2];
        cw[POS_D3] = d[3];
        cw[POS_P1] = d[0] ^ d[1] ^ d[3];
        cw[POS_P2] = d[0] ^ d[2] ^ d[3];
        cw[POS_P4] = d[1] ^ d[2] ^ d[3];
        cw[POS_P0] = ^cw[6:0];
        return cw;
    endfunction

    // The syndrome value is the 1-based position of a single flipped bit
    // within cw[6:0], so the bit to correct is cw[s-1].
    function automatic logic [2:0] syndrome(input logic [7:0] cw);
        logic s1;
        logic s2;
        logic s4;
        s1 = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
        s2 = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
        s4 = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
        return {s4, s2, s1};
    endfunction

endpackage

// File: rtl/hamming74_secded_dec.sv
// ---------------------------------------------------------------------------
// hamming74_secded_dec
// Combinational SECDED (8,4) decoder. Classifies a codeword and returns the
// corrected codeword (unchanged for clean and double-error words).
// Ports:
//   cw_i    [7:0] : codeword as read from memory
//   cw_o    [7:0] : corrected codeword
//   class_o [1:0] : err_class_e value (CLEAN, SINGLE, PARITY, DOUBLE)
// ---------------------------------------------------------------------------
module hamming74_secded_dec
    import hamming74_pkg::*;
(
    input  logic [7:0] cw_i,
    output logic [7:0] cw_o,
    output logic [1:0] class_o
);

    logic [2:0] syn;
    logic       par;
    err_class_e cls;

    always_comb begin
        syn  = syndrome(cw_i);
        par  = ^cw_i;
        cw_o = cw_i;
        cls  = ERR_CLEAN;
        if (syn != 3'd0 && par) begin
            cls  = ERR_SINGLE;
            cw_o = cw_i ^ (8'd1 << (syn - 3'd1));
        end else if (syn == 3'd0 && par) begin
            // Only the overall parity bit disagrees.
            cls  = ERR_PARITY;
            cw_o = cw_i ^ (8'd1 << POS_P0);
        end else if (syn != 3'd0 && !par) begin
            cls = ERR_DOUBLE;
        end
    end

    assign class_o = cls;

endmodule

// File: rtl/hamming74_scrubber.sv
// ---------------------------------------------------------------------------
// hamming74_scrubber
// Walks addresses 0..DEPTH-1 of a single-port synchronous codeword RAM,
// decodes each word, writes back corrected words and counts errors.
// Parameters: DEPTH (words per pass), ADDR_W (address width), CNT_W (counter
// width, counters saturate at all-ones).
// Ports:
//   i_clk, i_rst_n       : clock, async active-low reset
//   i_start              : level, sampled only while idle
//   o_mem_addr, o_mem_re : RAM address and read strobe (data next cycle)
//   i_mem_rdata          : RAM read data
//   o_mem_we, o_mem_wdata: RAM write strobe and corrected codeword
//   o_busy, o_done       : pass in progress / one-cycle end-of-pass pulse
//   o_cnt_1bit           : corrected errors this pass (incl. parity-only)
//   o_cnt_2bit           : uncorrectable errors this pass
//   o_fail_valid/addr    : first uncorrectable address of this pass
// Memory handshake: o_mem_re in cycle t means i_mem_rdata is valid in t+1;
// o_mem_we in cycle t commits o_mem_wdata at o_mem_addr on the edge ending t.
// The two strobes are decoded from distinct states and never overlap.
// ---------------------------------------------------------------------------
module hamming74_scrubber
    import hamming74_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_re,
    input  logic [7:0]        i_mem_rdata,
    output logic              o_mem_we,
    output logic [7:0]        o_mem_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic [CNT_W-1:0]  o_cnt_1bit,
    output logic [CNT_W-1:0]  o_cnt_2bit,
    output logic              o_fail_valid,
    output logic [ADDR_W-1:0] o_fail_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic [CNT_W-1:0]   cnt1_q, cnt1_d;
    logic [CNT_W-1:0]   cnt2_q, cnt2_d;
    logic               fail_valid_q, fail_valid_d;
    logic [ADDR_W-1:0]  fail_addr_q, fail_addr_d;

    logic [7:0]         dec_cw;
    logic [1:0]         dec_class;
    logic               advance;

    hamming74_secded_dec u_dec (
        .cw_i    (i_mem_rdata),
        .cw_o    (dec_cw),
        .class_o (dec_class)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt1_q       <= '0;
            cnt2_q       <= '0;
            fail_valid_q <= 1'b0;
            fail_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt1_q       <= cnt1_d;
            cnt2_q       <= cnt2_d;
            fail_valid_q <= fail_valid_d;
            fail_addr_q  <= fail_addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt1_d       = cnt1_q;
        cnt2_d       = cnt2_q;
        fail_valid_d = fail_valid_q;
        fail_addr_d  = fail_addr_q;
        advance      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    addr_d       = '0;
                    cnt1_d       = '0;
                    cnt2_d       = '0;
                    fail_valid_d = 1'b0;
                    fail_addr_d  = '0;
                    state_d      = ST_RD;
                end
            end
            ST_RD: begin
                state_d = ST_CHK;
            end
            ST_CHK: begin
                wdata_d = dec_cw;
                case (err_class_e'(dec_class))
                    ERR_SINGLE, ERR_PARITY: begin
                        if (cnt1_q != CNT_MAX) cnt1_d = cnt1_q + CNT_W'(1);
                        state_d = ST_WR;
                    end
                    ERR_DOUBLE: begin
                        if (cnt2_q != CNT_MAX) cnt2_d = cnt2_q + CNT_W'(1);
                        // Only the first uncorrectable address of a pass is kept.
                        if (!fail_valid_q) begin
                            fail_valid_d = 1'b1;
                            fail_addr_d  = addr_q;
                        end
                        advance = 1'b1;
                    end
                    default: begin
                        advance = 1'b1;
                    end
                endcase
            end
            ST_WR: begin
                advance = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The address parks at the last word; only a new start rewinds it.
        if (advance) begin
            if (addr_q == LAST_ADDR) begin
                state_d = ST_DONE;
            end else begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = ST_RD;
            end
        end
    end

    assign o_mem_addr   = addr_q;
    assign o_mem_re     = (state_q == ST_RD);
    assign o_mem_we     = (state_q == ST_WR);
    assign o_mem_wdata  = wdata_q;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_done       = (state_q == ST_DONE);
    assign o_cnt_1bit   = cnt1_q;
    assign o_cnt_2bit   = cnt2_q;
    assign o_fail_valid = fail_valid_q;
    assign o_fail_addr  = fail_addr_q;

endmodule

// File: tb/tb_hamming74_scrubber.sv
// ---------------------------------------------------------------------------
// tb_hamming74_scrubber
// Two scrubbers (8-bit and 2-bit counters) each scrub their own RAM model;
// both RAMs are loaded with the same image before every pass.
// ---------------------------------------------------------------------------
module tb_hamming74_scrubber;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start;

    // ---------------- DUT A (CNT_W = 8) ----------------
    logic [3:0] a_addr;
    logic       a_re, a_we, a_busy, a_done, a_fv;
    logic [7:0] a_rdata, a_wdata, a_c1, a_c2;
    logic [3:0] a_fa;

    hamming74_scrubber #(.DEPTH(16), .ADDR_W(4), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .o_mem_addr(a_addr), .o_mem_re(a_re), .i_mem_rdata(a_rdata),
        .o_mem_we(a_we), .o_mem_wdata(a_wdata),
        .o_busy(a_busy), .o_done(a_done),
        .o_cnt_1bit(a_c1), .o_cnt_2bit(a_c2),
        .o_fail_valid(a_fv), .o_fail_addr(a_fa)
    );

    // ---------------- DUT B (CNT_W = 2) ----------------
    logic [3:0] b_addr;
    logic       b_re, b_we, b_busy, b_done, b_fv;
    logic [7:0] b_rdata, b_wdata;
    logic [1:0] b_c1, b_c2;
    logic [3:0] b_fa;

    hamming74_scrubber #(.DEPTH(16), .ADDR_W(4), .CNT_W(2)) dut_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .o_mem_addr(b_addr), .o_mem_re(b_re), .i_mem_rdata(b_rdata),
        .o_mem_we(b_we), .o_mem_wdata(b_wdata),
        .o_busy(b_busy), .o_done(b_done),
        .o_cnt_1bit(b_c1), .o_cnt_2bit(b_c2),
        .o_fail_valid(b_fv), .o_fail_addr(b_fa)
    );

    // ---------------- RAM models ----------------
    // Hand-computed encode(i) for i = 0..15.
    logic [7:0] enc_tab [16] = '{8'h00, 8'h87, 8'h99, 8'h1E, 8'hAA, 8'h2D, 8'h33, 8'hB4,
                                 8'h4B, 8'hCC, 8'hD2, 8'h55, 8'hE1, 8'h66, 8'h78, 8'hFF};
    logic [7:0] mem_a [16];
    logic [7:0] mem_b [16];
    logic [7:0] img   [16];
    logic       load_en;

    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < 16; i++) begin
                mem_a[i] <= img[i];
                mem_b[i] <= img[i];
            end
        end else begin
            if (a_we) mem_a[a_addr] <= a_wdata;
            if (b_we) mem_b[b_addr] <= b_wdata;
        end
        if (a_re) a_rdata <= mem_a[a_addr];
        if (b_re) b_rdata <= mem_b[b_addr];
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [11:0] exp_q [$];   // expected writes {addr, data}
    int overlap_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin : wr_monitor
        logic [11:0] e;
        if (a_re && a_we) overlap_cnt++;
        if (a_we) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", {20'd0, a_addr, a_wdata}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr_data", {20'd0, a_addr, a_wdata}, {20'd0, e});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_clean();
        for (int i = 0; i < 16; i++) img[i] = enc_tab[i];
    endtask

    task automatic commit_image();
        @(negedge clk); load_en = 1'b1;
        @(negedge clk); load_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {11'd0, a_addr, a_re, a_we, a_wdata, a_busy, a_done, a_fv, a_fa}, 32'd0);
        check({tag, "_cnt"}, {16'd0, a_c1, a_c2}, 32'd0);
    endtask

    // Pulses start for one edge (edge k); n counts cycles after k.
    task automatic run_pass(input string tag, input int exp_done);
        int got;
        got = -1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({tag, "_busy_k1"}, {31'd0, a_busy}, 32'd1);
        check({tag, "_rd_k1"}, {27'd0, a_re, a_addr}, 32'h10);
        for (int n = 1; n <= 300; n++) begin
            if (n > 1) @(negedge clk);
            if (a_done) begin
                got = n;
                break;
            end
        end
        check({tag, "_done_cycle"}, got, exp_done);
        if (got > 0) begin
            @(negedge clk);
            check({tag, "_after_done"}, {30'd0, a_done, a_busy}, 32'd0);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int         n_ov;
        logic [3:0] oa0; logic [7:0] ov0;
        logic [3:0] oa1; logic [7:0] ov1;
        int         exp_done;
        int         c1;
        int         c2;
        logic       fv;
        logic [3:0] fa;
        int         nw;
        logic [3:0] wa0; logic [7:0] wd0;
        logic [3:0] wa1; logic [7:0] wd1;
        int         sat_c1;
    } row_t;

    row_t rows [6];

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        load_en = 1'b0;
        for (int i = 0; i < 16; i++) img[i] = 8'h00;

        // n_ov  oa0    ov0     oa1    ov1    done c1 c2 fv   fa    nw wa0   wd0     wa1    wd1    satc1
        rows[0] = '{0, 4'd0, 8'h00, 4'd0, 8'h00, 33, 0, 0, 1'b0, 4'd0, 0, 4'd0, 8'h00, 4'd0, 8'h00, 0};
        rows[1] = '{1, 4'd3, 8'h3D, 4'd0, 8'h00, 34, 1, 0, 1'b0, 4'd0, 1, 4'd3, 8'h2D, 4'd0, 8'h00, 1};
        rows[2] = '{1, 4'd7, 8'hAD, 4'd0, 8'h00, 34, 1, 0, 1'b0, 4'd0, 1, 4'd7, 8'h2D, 4'd0, 8'h00, 1};
        rows[3] = '{2, 4'd9, 8'h2E, 4'd12, 8'h2E, 33, 0, 2, 1'b1, 4'd9, 0, 4'd0, 8'h00, 4'd0, 8'h00, 0};
        rows[4] = '{2, 4'd0, 8'h40, 4'd15, 8'hFE, 35, 2, 0, 1'b0, 4'd0, 2, 4'd0, 8'h00, 4'd15, 8'hFF, 2};
        rows[5] = '{2, 4'd1, 8'h93, 4'd10, 8'h52, 34, 1, 1, 1'b1, 4'd1, 1, 4'd10, 8'hD2, 4'd0, 8'h00, 1};

        // ---- reset state ----
        #12;
        check_reset_outputs("reset");
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_reset");

        // ---- table-driven passes ----
        for (int r = 0; r < 6; r++) begin
            string tag;
            tag = $sformatf("row%0d", r);
            load_clean();
            if (rows[r].n_ov > 0) img[rows[r].oa0] = rows[r].ov0;
            if (rows[r].n_ov > 1) img[rows[r].oa1] = rows[r].ov1;
            commit_image();
            if (rows[r].nw > 0) exp_q.push_back({rows[r].wa0, rows[r].wd0});
            if (rows[r].nw > 1) exp_q.push_back({rows[r].wa1, rows[r].wd1});
            overlap_cnt = 0;
            run_pass(tag, rows[r].exp_done);
            check({tag, "_c1"}, {24'd0, a_c1}, rows[r].c1);
            check({tag, "_c2"}, {24'd0, a_c2}, rows[r].c2);
            check({tag, "_fail"}, {27'd0, a_fv, a_fa}, {27'd0, rows[r].fv, rows[r].fa});
            check({tag, "_sat_c1"}, {30'd0, b_c1}, rows[r].sat_c1);
            check({tag, "_sat_misc"}, {23'd0, b_c2, b_fv, b_fa, b_busy, b_done},
                  {23'd0, 2'(rows[r].c2), rows[r].fv, rows[r].fa, 1'b0, 1'b0});
            check({tag, "_wr_left"}, exp_q.size(), 0);
            check({tag, "_re_we_excl"}, overlap_cnt, 0);
            if (rows[r].nw > 0) check({tag, "_mem_w0"}, {24'd0, mem_a[rows[r].wa0]}, {24'd0, rows[r].wd0});
            if (rows[r].nw > 1) check({tag, "_mem_w1"}, {24'd0, mem_a[rows[r].wa1]}, {24'd0, rows[r].wd1});
            exp_q.delete();
        end

        // ---- counter saturation: five correctable words ----
        load_clean();
        for (int i = 1; i < 10; i += 2) begin
            img[i] = 8'h3D;
            exp_q.push_back({4'(i), 8'h2D});
        end
        commit_image();
        run_pass("sat", 38);
        check("sat_a_c1", {24'd0, a_c1}, 32'd5);
        check("sat_b_c1", {30'd0, b_c1}, 32'd3);
        check("sat_wr_left", exp_q.size(), 0);
        for (int i = 1; i < 10; i += 2)
            check($sformatf("sat_b_mem%0d", i), {24'd0, mem_b[i]}, 32'h2D);
        exp_q.delete();

        // ---- start held high: busy-start ignored, one IDLE cycle, restart ----
        begin
            int got;
            load_clean();
            commit_image();
            got = -1;
            @(negedge clk); start = 1'b1;
            for (int n = 1; n <= 300; n++) begin
                @(negedge clk);
                if (a_done) begin
                    got = n;
                    break;
                end
            end
            check("hold_done_cycle", got, 33);
            @(negedge clk);
            check("hold_idle_gap", {30'd0, a_busy, a_re}, 32'd0);
            @(negedge clk);
            check("hold_restart_rd", {26'd0, a_busy, a_re, a_addr}, 32'h30);
            start = 1'b0;
            got = -1;
            for (int m = 2; m <= 300; m++) begin
                @(negedge clk);
                if (a_done) begin
                    got = m;
                    break;
                end
            end
            check("hold_second_done", got, 33);
        end

        // ---- reset during the WR cycle of address 3 ----
        begin
            int got;
            load_clean();
            img[3] = 8'h3D;
            commit_image();
            exp_q.push_back({4'd3, 8'h2D});
            got = -1;
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
            for (int n = 1; n <= 100; n++) begin
                if (n > 1) @(negedge clk);
                if (a_we) begin
                    got = n;
                    break;
                end
            end
            check("rstwr_wr_cycle", got, 9);
            check("rstwr_wr_addr", {28'd0, a_addr}, 32'd3);
            #2 rst_n = 1'b0;
            #1;
            check("rstwr_we_drop", {31'd0, a_we}, 32'd0);
            check_reset_outputs("rstwr");
            @(negedge clk);
            @(negedge clk); rst_n = 1'b1;
            check("rstwr_mem_untouched", {24'd0, mem_a[3]}, 32'h3D);
            check("rstwr_wr_left", exp_q.size(), 0);
            exp_q.delete();
            exp_q.push_back({4'd3, 8'h2D});
            run_pass("rstwr_rerun", 34);
            check("rstwr_rerun_c1", {24'd0, a_c1}, 32'd1);
            check("rstwr_rerun_mem", {24'd0, mem_a[3]}, 32'h2D);
            check("rstwr_rerun_wr_left", exp_q.size(), 0);
        end

        // ---- final report ----
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
